// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package debounce_pkg;

   // Per-channel debounce state: stable low, waiting to go high, stable high, waiting to go low
   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   // Width of the per-channel tick counter; never narrower than one bit
   function automatic int cnt_width(input int n_ticks);
      return (n_ticks > 1) ? $clog2(n_ticks) : 1;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability FSM and edge pulses.
// The sample tick is supplied from outside so many channels share one divider.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int N_TICKS = 3
)(
   input  logic clk,
   input  logic reset,
   input  logic sw,
   input  logic tick,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int            CW   = cnt_width(N_TICKS);
   localparam logic [CW-1:0] LAST = CW'(N_TICKS - 1);

   logic          sync1;
   logic          sw_s;
   db_state_t     state;
   logic [CW-1:0] cnt;

   // Bring the raw switch level into the clk domain before anything looks at it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sw_s  <= 1'b0;
      end else begin
         sync1 <= sw;
         sw_s  <= sync1;
      end
   end

   // Stability FSM: the output flips only after the input has held its new level
   // across N_TICKS sample ticks; any return to the old level aborts silently,
   // and that abort wins over a tick arriving in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ZERO;
         cnt   <= '0;
         db    <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            ZERO: begin
               db <= 1'b0;
               if (sw_s) begin
                  state <= WAIT1;
                  cnt   <= '0;
               end
            end
            WAIT1: begin
               if (!sw_s) begin
                  state <= ZERO;
               end else if (tick) begin
                  if (cnt == LAST) begin
                     state <= ONE;
                     db    <= 1'b1;
                     rise  <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ONE: begin
               db <= 1'b1;
               if (!sw_s) begin
                  state <= WAIT0;
                  cnt   <= '0;
               end
            end
            WAIT0: begin
               if (sw_s) begin
                  state <= ONE;
               end else if (tick) begin
                  if (cnt == LAST) begin
                     state <= ZERO;
                     db    <= 1'b0;
                     fall  <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= ZERO;
               db    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: one shared sample-tick divider feeding
// N_CH independent debounce channels.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int TICK_DIV = 1_000_000,
   parameter int N_TICKS  = 3
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            tick
);

   localparam int            TW       = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_TOP = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;

   assign tick = (tick_cnt == TICK_TOP);

   // Free-running divider; tick is high for the single cycle the count sits at its top value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .N_TICKS (N_TICKS)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .sw    (sw[i]),
         .tick  (tick),
         .db    (db[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: a reference model predicts every
// cycle's outputs into a queue, a monitor pops and compares on the other edge.
module tb_multi_debouncer;

   localparam int N_CH     = 4;
   localparam int TICK_DIV = 4;
   localparam int N_TICKS  = 3;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N_CH-1:0] sw    = '1;
   logic [N_CH-1:0] db;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic            tick;

   int n_tests = 0;
   int n_fail  = 0;

   multi_debouncer #(
      .N_CH     (N_CH),
      .TICK_DIV (TICK_DIV),
      .N_TICKS  (N_TICKS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (sw),
      .db    (db),
      .rise  (rise),
      .fall  (fall),
      .tick  (tick)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Expected {tick, db, rise, fall} after each clock edge
   logic [3*N_CH:0] sbq[$];
   // Raw switch samples still travelling through the two-cycle input delay
   logic [N_CH-1:0] swq[$];

   logic [N_CH-1:0] m_db = '0;
   bit              m_wait[N_CH];
   int              m_tc[N_CH];
   int              m_cyc = 0;
   logic [N_CH-1:0] m_ss;
   logic [N_CH-1:0] m_rise;
   logic [N_CH-1:0] m_fall;
   bit              m_tk;

   int rise_cnt[N_CH];
   int fall_cnt[N_CH];
   bit seen_all_rise = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Callers sit 2 time units after a rising edge; sw then holds for 'cycles' edges
   task automatic applyStimulus(input logic [N_CH-1:0] v, input int cycles);
      sw = v;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: a channel flips once its delayed input has disagreed with
   // the clean level across N_TICKS ticks, not counting a tick on the first
   // disagreeing edge; agreement at any edge discards the progress
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_db  = '0;
         m_cyc = 0;
         swq.delete();
         swq.push_back('0);
         swq.push_back('0);
         for (int i = 0; i < N_CH; i++) begin
            m_wait[i] = 0;
            m_tc[i]   = 0;
         end
         sbq.delete();
         sbq.push_back('0);
      end else begin
         m_ss = swq.pop_front();
         swq.push_back(sw);
         m_tk = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
         m_cyc++;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < N_CH; i++) begin
            if (m_ss[i] == m_db[i]) begin
               m_wait[i] = 0;
            end else if (!m_wait[i]) begin
               m_wait[i] = 1;
               m_tc[i]   = 0;
            end else if (m_tk) begin
               m_tc[i]++;
               if (m_tc[i] == N_TICKS) begin
                  m_db[i]   = m_ss[i];
                  m_wait[i] = 0;
                  if (m_ss[i]) m_rise[i] = 1'b1;
                  else         m_fall[i] = 1'b1;
               end
            end
         end
         sbq.push_back({((m_cyc % TICK_DIV) == TICK_DIV - 1), m_db, m_rise, m_fall});
      end
   end

   // Monitor: compare the DUT against the oldest prediction and tally pulses
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         checkOutput("outputs", 32'({tick, db, rise, fall}), 32'(sbq.pop_front()));
      end
      for (int i = 0; i < N_CH; i++) begin
         if (rise[i]) rise_cnt[i]++;
         if (fall[i]) fall_cnt[i]++;
      end
      if (rise == '1) seen_all_rise = 1;
      if ((rise & fall) != '0) checkOutput("rise_fall_overlap", 32'(rise & fall), 32'h0);
   end

   int r0[N_CH];
   int f0[N_CH];
   logic [N_CH-1:0] v;

   task automatic snapCounts();
      for (int i = 0; i < N_CH; i++) begin
         r0[i] = rise_cnt[i];
         f0[i] = fall_cnt[i];
      end
   endtask

   initial begin
      // Reset held with all switches high
      @(posedge clk);
      #2;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      checkOutput("reset_db", 32'(db), 32'h0);
      checkOutput("reset_tick", 32'(tick), 32'h0);
      snapCounts();
      reset = 1'b1;
      applyStimulus(4'hF, 20);
      for (int i = 0; i < N_CH; i++) checkOutput($sformatf("post_reset_rise%0d", i), 32'(rise_cnt[i] - r0[i]), 32'd1);
      applyStimulus(4'h0, 20);

      // Clean press on ch0
      snapCounts();
      applyStimulus(4'b0001, 20);
      checkOutput("press_rise0", 32'(rise_cnt[0] - r0[0]), 32'd1);
      checkOutput("press_fall0", 32'(fall_cnt[0] - f0[0]), 32'd0);
      checkOutput("press_db0", 32'(db[0]), 32'd1);

      // Bouncing ch1: toggles every 3 cycles, then settles high
      snapCounts();
      for (int k = 0; k < 14; k++) applyStimulus(sw ^ 4'b0010, 3);
      checkOutput("bounce_rise1_during", 32'(rise_cnt[1] - r0[1]), 32'd0);
      applyStimulus(sw | 4'b0010, 20);
      checkOutput("bounce_rise1", 32'(rise_cnt[1] - r0[1]), 32'd1);

      // Release glitch on ch2: a short low is ignored, a held low falls once
      applyStimulus(sw | 4'b0100, 20);
      snapCounts();
      applyStimulus(sw & 4'b1011, 6);
      applyStimulus(sw | 4'b0100, 12);
      checkOutput("glitch_fall2", 32'(fall_cnt[2] - f0[2]), 32'd0);
      checkOutput("glitch_db2", 32'(db[2]), 32'd1);
      applyStimulus(sw & 4'b1011, 20);
      checkOutput("release_fall2", 32'(fall_cnt[2] - f0[2]), 32'd1);

      // Simultaneous press on all channels
      applyStimulus(4'h0, 20);
      seen_all_rise = 0;
      applyStimulus(4'hF, 20);
      checkOutput("simul_rise", 32'(seen_all_rise), 32'd1);
      checkOutput("simul_db", 32'(db), 32'hF);

      // Async reset pulse between edges with switches held high
      snapCounts();
      reset = 1'b0;
      #1;
      checkOutput("async_db", 32'(db), 32'h0);
      checkOutput("async_fall", 32'(fall), 32'h0);
      reset = 1'b1;
      #1;
      applyStimulus(4'hF, 20);
      for (int i = 0; i < N_CH; i++) begin
         checkOutput($sformatf("rearm_rise%0d", i), 32'(rise_cnt[i] - r0[i]), 32'd1);
         checkOutput($sformatf("rearm_fall%0d", i), 32'(fall_cnt[i] - f0[i]), 32'd0);
      end

      // Random toggling; the scoreboard checks every cycle
      for (int c = 0; c < 800; c++) begin
         v = sw;
         for (int i = 0; i < N_CH; i++) begin
            if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
         end
         applyStimulus(v, 1);
      end
      applyStimulus(sw, 20);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
